// File: rtl/seguidor_pkg.sv
// Shared types for the line follower: state encoding, motor direction codes
// and the left/centre/right classification of the debounced sensor bits.
package seguidor_pkg;

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        RECTO    = 3'd1,
        GIRO_IZQ = 3'd2,
        GIRO_DER = 3'd3,
        BUSCAR   = 3'd4,
        PERDIDO  = 3'd5
    } estado_t;

    // {INx, INy} as driven onto the L298 direction pins
    typedef enum logic [1:0] {
        DIR_OFF = 2'b00,
        DIR_REV = 2'b01,
        DIR_FWD = 2'b10
    } dir_t;

    typedef struct packed {
        logic izq;
        logic cen;
        logic der;
    } clase_t;

    localparam int MAX_SENS = 7;

    function automatic clase_t clasificar(input logic [MAX_SENS-1:0] s, input int n);
        clase_t                c;
        logic [MAX_SENS-1:0]   t;
        int                    centro;
        c      = '0;
        centro = n / 2;
        for (int i = 0; i < MAX_SENS; i++) begin
            t = s >> i;
            if (i < n) begin
                if (i > centro)
                    c.izq = c.izq | t[0];
                else if (i < centro)
                    c.der = c.der | t[0];
                else
                    c.cen = t[0];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pwm_canal.sv
// One PWM channel: duty/direction shadows loaded at the counter wrap, and a
// forced-off period whenever the commanded direction flips fwd<->rev.
module pwm_canal
    import seguidor_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] i_cnt_nxt,
    input  logic                i_wrap,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [1:0]          i_dir,
    output logic                o_en,
    output logic                o_in_a,
    output logic                o_in_b
);

    logic [PWM_BITS-1:0] r_duty_sh;
    logic [1:0]          r_dir_sh;
    logic                r_muerto;
    logic                r_en;

    logic                w_reversa;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_muerto_nxt;

    assign w_reversa    = (i_dir != DIR_OFF) && (r_dir_sh != DIR_OFF) && (i_dir != r_dir_sh);
    assign w_duty_nxt   = i_wrap ? i_duty : r_duty_sh;
    assign w_muerto_nxt = i_wrap ? w_reversa : r_muerto;

    // Compare against post-edge counter/shadow so EN lines up with the IN pins at the wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty_sh <= '0;
            r_dir_sh  <= DIR_OFF;
            r_muerto  <= 1'b0;
            r_en      <= 1'b0;
        end else begin
            if (i_wrap) begin
                r_duty_sh <= i_duty;
                r_dir_sh  <= i_dir;
            end
            r_muerto <= w_muerto_nxt;
            r_en     <= !w_muerto_nxt && (i_cnt_nxt < w_duty_nxt);
        end
    end

    assign o_en   = r_en;
    assign o_in_a = r_dir_sh[1];
    assign o_in_b = r_dir_sh[0];

endmodule

// File: rtl/seguidor_linea_pwm.sv
// Line follower controller for an L298 driver: sensor sync/debounce, tracking
// FSM with lost-line search and timeout, and two shadowed PWM channels.
module seguidor_linea_pwm
    import seguidor_pkg::*;
#(
    parameter int N_SENS     = 3,
    parameter int PWM_BITS   = 8,
    parameter int DIV_PWM    = 1,
    parameter int DEB_CICLOS = 4,
    parameter int V_RECTO    = 200,
    parameter int V_GIRO     = 80,
    parameter int V_BUSCA    = 120,
    parameter int T_PERDIDO  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              habilitar,
    input  logic [N_SENS-1:0] sensores,
    output logic              ENA,
    output logic              IN1,
    output logic              IN2,
    output logic              ENB,
    output logic              IN3,
    output logic              IN4,
    output logic [2:0]        estado
);

    localparam int DEB_W = $clog2(DEB_CICLOS + 1);
    localparam int DIV_W = (DIV_PWM > 1) ? $clog2(DIV_PWM) : 1;
    localparam int TO_W  = $clog2(T_PERDIDO + 1);

    logic [N_SENS-1:0]   r_sinc1;
    logic [N_SENS-1:0]   r_sinc2;
    logic [N_SENS-1:0]   w_deb;

    logic [DIV_W-1:0]    r_div;
    logic [PWM_BITS-1:0] r_cnt;
    logic                w_tick;
    logic                w_wrap;
    logic [PWM_BITS-1:0] w_cnt_nxt;

    estado_t             r_estado;
    estado_t             w_estado_nxt;
    estado_t             w_decision;
    clase_t              w_cls;
    logic                w_alguno;
    logic                r_ult_der;
    logic [TO_W-1:0]     r_timeout;

    logic [PWM_BITS-1:0] w_duty_a;
    logic [PWM_BITS-1:0] w_duty_b;
    logic [1:0]          w_dir_a;
    logic [1:0]          w_dir_b;
    logic                w_en_a;
    logic                w_en_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sinc1 <= '0;
            r_sinc2 <= '0;
        end else begin
            r_sinc1 <= sensores;
            r_sinc2 <= r_sinc1;
        end
    end

    for (genvar g = 0; g < N_SENS; g++) begin : g_deb
        logic             r_bit;
        logic [DEB_W-1:0] r_deb_cnt;

        // Any clock where the synchronized bit agrees with the accepted value restarts the count
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_bit     <= 1'b0;
                r_deb_cnt <= '0;
            end else if (r_sinc2[g] != r_bit) begin
                if (r_deb_cnt == DEB_W'(DEB_CICLOS - 1)) begin
                    r_bit     <= r_sinc2[g];
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end

        assign w_deb[g] = r_bit;
    end

    assign w_tick    = (r_div == DIV_W'(DIV_PWM - 1));
    assign w_wrap    = w_tick && (r_cnt == '1);
    assign w_cnt_nxt = w_tick ? r_cnt + PWM_BITS'(1) : r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_cnt <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            r_cnt <= w_cnt_nxt;
        end
    end

    assign w_cls    = clasificar(MAX_SENS'(w_deb), N_SENS);
    assign w_alguno = w_cls.izq | w_cls.cen | w_cls.der;

    always_comb begin
        w_decision = RECTO;
        if (!w_alguno)
            w_decision = BUSCAR;
        else if (w_cls.izq && !w_cls.der)
            w_decision = GIRO_IZQ;
        else if (w_cls.der && !w_cls.izq)
            w_decision = GIRO_DER;
    end

    always_comb begin
        w_estado_nxt = r_estado;
        if (!habilitar) begin
            w_estado_nxt = PARADO;
        end else begin
            case (r_estado)
                PARADO, RECTO, GIRO_IZQ, GIRO_DER: w_estado_nxt = w_decision;
                BUSCAR: begin
                    if (w_alguno)
                        w_estado_nxt = w_decision;
                    else if (w_wrap && (r_timeout == TO_W'(T_PERDIDO - 1)))
                        w_estado_nxt = PERDIDO;
                end
                PERDIDO: begin
                    if (w_alguno)
                        w_estado_nxt = w_decision;
                end
                default: w_estado_nxt = PARADO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado  <= PARADO;
            r_ult_der <= 1'b0;
            r_timeout <= '0;
        end else begin
            r_estado <= w_estado_nxt;
            if (w_estado_nxt == GIRO_IZQ)
                r_ult_der <= 1'b0;
            else if (w_estado_nxt == GIRO_DER)
                r_ult_der <= 1'b1;
            if ((r_estado == BUSCAR) && (w_estado_nxt == BUSCAR)) begin
                if (w_wrap)
                    r_timeout <= r_timeout + TO_W'(1);
            end else begin
                r_timeout <= '0;
            end
        end
    end

    // Motor A is the left wheel, motor B the right wheel
    always_comb begin
        w_duty_a = '0;
        w_duty_b = '0;
        w_dir_a  = DIR_OFF;
        w_dir_b  = DIR_OFF;
        case (r_estado)
            RECTO: begin
                w_duty_a = PWM_BITS'(V_RECTO);
                w_duty_b = PWM_BITS'(V_RECTO);
                w_dir_a  = DIR_FWD;
                w_dir_b  = DIR_FWD;
            end
            GIRO_IZQ: begin
                w_duty_a = PWM_BITS'(V_GIRO);
                w_duty_b = PWM_BITS'(V_RECTO);
                w_dir_a  = DIR_FWD;
                w_dir_b  = DIR_FWD;
            end
            GIRO_DER: begin
                w_duty_a = PWM_BITS'(V_RECTO);
                w_duty_b = PWM_BITS'(V_GIRO);
                w_dir_a  = DIR_FWD;
                w_dir_b  = DIR_FWD;
            end
            BUSCAR: begin
                w_duty_a = PWM_BITS'(V_BUSCA);
                w_duty_b = PWM_BITS'(V_BUSCA);
                w_dir_a  = r_ult_der ? DIR_FWD : DIR_REV;
                w_dir_b  = r_ult_der ? DIR_REV : DIR_FWD;
            end
            default: ;
        endcase
    end

    pwm_canal #(.PWM_BITS(PWM_BITS)) u_canal_a (
        .clk       (clk),
        .reset     (reset),
        .i_cnt_nxt (w_cnt_nxt),
        .i_wrap    (w_wrap),
        .i_duty    (w_duty_a),
        .i_dir     (w_dir_a),
        .o_en      (w_en_a),
        .o_in_a    (IN1),
        .o_in_b    (IN2)
    );

    pwm_canal #(.PWM_BITS(PWM_BITS)) u_canal_b (
        .clk       (clk),
        .reset     (reset),
        .i_cnt_nxt (w_cnt_nxt),
        .i_wrap    (w_wrap),
        .i_duty    (w_duty_b),
        .i_dir     (w_dir_b),
        .o_en      (w_en_b),
        .o_in_a    (IN3),
        .o_in_b    (IN4)
    );

    // Enable drop cuts the bridge at once rather than at the next wrap
    assign ENA    = w_en_a & habilitar;
    assign ENB    = w_en_b & habilitar;
    assign estado = r_estado;

endmodule

// File: tb/tb_seguidor_linea_pwm.sv
// Scoreboard bench for seguidor_linea_pwm with default parameters.
module tb_seguidor_linea_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       habilitar = 1'b0;
    logic [2:0] sensores = 3'b000;
    logic       ENA, IN1, IN2, ENB, IN3, IN4;
    logic [2:0] estado;

    seguidor_linea_pwm dut (
        .clk       (clk),
        .reset     (reset),
        .habilitar (habilitar),
        .sensores  (sensores),
        .ENA       (ENA),
        .IN1       (IN1),
        .IN2       (IN2),
        .ENB       (ENB),
        .IN3       (IN3),
        .IN4       (IN4),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    // Reference PWM counter: +1 every clock from reset, wraps at 256
    logic [7:0] tb_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 8'd0;
        else       tb_cnt <= tb_cnt + 8'd1;
    end

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic esperar(input string tag, input int val);
        sb.push_back('{tag, val});
    endtask

    task automatic comparar(input int obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got %0d expected none", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic wait_estado(input int exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (estado == exp[2:0]) break;
        end
    endtask

    task automatic wait_wrap();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_cnt != 8'd0 && n < 600);
    endtask

    task automatic wait_cnt(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_cnt != c[7:0] && n < 600);
    endtask

    // Called at the negedge right after a wrap; ends at count 255
    task automatic medir(output int na, output int nb, output int dirs);
        na = 0;
        nb = 0;
        dirs = {IN1, IN2, IN3, IN4};
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            na += int'(ENA);
            nb += int'(ENB);
        end
    endtask

    int na, nb, dirs, wraps, cambios;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        esperar("rst_estado", 0);
        esperar("rst_pins", 0);
        comparar(int'(estado));
        comparar(int'({ENA, IN1, IN2, ENB, IN3, IN4}));

        // Centre line -> RECTO
        reset = 1'b0;
        habilitar = 1'b1;
        sensores = 3'b010;
        esperar("recto_lat7", 1);
        wait_estado(1, 7);
        comparar(int'(estado));
        wait_wrap();
        esperar("recto_dirs", 4'b1010);
        esperar("recto_ena", 200);
        esperar("recto_enb", 200);
        medir(na, nb, dirs);
        comparar(dirs);
        comparar(na);
        comparar(nb);

        // Left -> GIRO_IZQ, then line lost -> search pivoting left
        sensores = 3'b100;
        esperar("giro_izq", 2);
        wait_estado(2, 10);
        comparar(int'(estado));
        wait_wrap();
        esperar("gizq_ena", 80);
        esperar("gizq_enb", 200);
        medir(na, nb, dirs);
        comparar(na);
        comparar(nb);

        sensores = 3'b000;
        esperar("buscar", 4);
        wait_estado(4, 10);
        comparar(int'(estado));
        wraps = 0;
        wait_wrap();
        wraps++;
        esperar("busca_izq_dirs", 4'b0110);
        esperar("busca_dead_ena", 0);
        esperar("busca_enb", 120);
        medir(na, nb, dirs);
        comparar(dirs);
        comparar(na);
        comparar(nb);
        wait_wrap();
        wraps++;
        esperar("busca_ena", 120);
        medir(na, nb, dirs);
        comparar(na);

        // Timeout: PERDIDO on the 10th wrap spent in BUSCAR
        while (wraps < 12) begin
            wait_wrap();
            wraps++;
            if (estado == 3'd5) break;
        end
        esperar("perdido", 5);
        esperar("perdido_wraps", 10);
        comparar(int'(estado));
        comparar(wraps);
        wait_wrap();
        esperar("perdido_pins", 0);
        esperar("perdido_en", 0);
        comparar(int'({ENA, IN1, IN2, ENB, IN3, IN4}));
        medir(na, nb, dirs);
        comparar(na + nb);

        // Right -> GIRO_DER, then lost again -> pivot right with B dead period
        sensores = 3'b001;
        esperar("giro_der", 3);
        wait_estado(3, 10);
        comparar(int'(estado));
        wait_wrap();
        esperar("gder_ena", 200);
        esperar("gder_enb", 80);
        medir(na, nb, dirs);
        comparar(na);
        comparar(nb);
        sensores = 3'b000;
        esperar("buscar_der", 4);
        wait_estado(4, 10);
        comparar(int'(estado));
        wait_wrap();
        esperar("busca_der_dirs", 4'b1001);
        esperar("busca_der_ena", 120);
        esperar("busca_der_dead_enb", 0);
        medir(na, nb, dirs);
        comparar(dirs);
        comparar(na);
        comparar(nb);

        // Back to RECTO: B reverses rev->fwd, so one dead B period
        sensores = 3'b010;
        esperar("recto2", 1);
        wait_estado(1, 10);
        comparar(int'(estado));
        wait_wrap();
        esperar("recto2_ena", 200);
        esperar("recto2_dead_enb", 0);
        medir(na, nb, dirs);
        comparar(na);
        comparar(nb);

        // 3-clock glitch on bit 0 must be rejected
        sensores = 3'b011;
        repeat (3) @(negedge clk);
        sensores = 3'b010;
        cambios = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (estado != 3'd1) cambios++;
        end
        esperar("glitch_estado", 0);
        comparar(cambios);
        wait_wrap();
        esperar("glitch_dirs", 4'b1010);
        esperar("glitch_ena", 200);
        esperar("glitch_enb", 200);
        medir(na, nb, dirs);
        comparar(dirs);
        comparar(na);
        comparar(nb);

        // Enable drop mid-period
        wait_cnt(100);
        esperar("pre_hab_en", 2'b11);
        comparar(int'({ENA, ENB}));
        habilitar = 1'b0;
        #1;
        esperar("hab_en_off", 0);
        esperar("hab_estado_hold", 1);
        comparar(int'({ENA, ENB}));
        comparar(int'(estado));
        @(negedge clk);
        esperar("hab_parado", 0);
        comparar(int'(estado));
        habilitar = 1'b1;
        esperar("rehab_recto", 1);
        wait_estado(1, 3);
        comparar(int'(estado));

        // Async reset mid-RECTO
        wait_cnt(50);
        esperar("pre_rst_pins", 6'b110110);
        comparar(int'({ENA, IN1, IN2, ENB, IN3, IN4}));
        reset = 1'b1;
        #1;
        esperar("rst_async_pins", 0);
        esperar("rst_async_estado", 0);
        comparar(int'({ENA, IN1, IN2, ENB, IN3, IN4}));
        comparar(int'(estado));
        @(negedge clk);
        reset = 1'b0;
        esperar("post_rst_recto", 1);
        wait_estado(1, 7);
        comparar(int'(estado));

        // Both sides active -> RECTO
        sensores = 3'b100;
        esperar("pre_ambos_izq", 2);
        wait_estado(2, 10);
        comparar(int'(estado));
        sensores = 3'b101;
        esperar("ambos_recto", 1);
        wait_estado(1, 10);
        comparar(int'(estado));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seguidor_linea_pwm.md
Name: seguidor_linea_pwm

Overview:
Next-generation line follower controller for the L298 dual H-bridge motor driver. It takes N debounced reflective sensors and runs a tracking FSM with lost-line search and timeout. It drives both motors with PWM speed control and full direction control (IN1..IN4), and sits between the sensor pins and the motor driver pins at top level.

Parameters:
N_SENS, 3, number of line sensors; odd, 3..7; bit 0 = rightmost, bit N_SENS-1 = leftmost, middle bit = centre
PWM_BITS, 8, PWM counter width
DIV_PWM, 1, clocks per PWM counter increment (>=1)
DEB_CICLOS, 4, consecutive stable clocks required to accept a sensor change
V_RECTO, 200, duty for straight running and for the outer wheel in turns
V_GIRO, 80, duty for the inner wheel in turns
V_BUSCA, 120, duty for both wheels while searching
T_PERDIDO, 10, PWM periods spent in BUSCAR before declaring PERDIDO

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
habilitar  input  1  run enable; 0 forces PARADO
sensores  input  N_SENS  raw sensor bits, 1 = line detected, asynchronous to clk
ENA  output  1  PWM enable, motor A (left)
IN1  output  1  motor A direction bit 1
IN2  output  1  motor A direction bit 2
ENB  output  1  PWM enable, motor B (right)
IN3  output  1  motor B direction bit 1
IN4  output  1  motor B direction bit 2
estado  output  3  current FSM state, for debug LEDs

Behaviour:
- Reset (async, active-high): all outputs 0, FSM=PARADO, PWM counter=0, shadow duty/direction=0, ultimo_lado=izq, debounce counters=0, timeout counter=0.
- Input path: 2-FF synchronizer per sensor. A debounced bit updates only after its synchronized value differs from the current debounced value for DEB_CICLOS consecutive clocks. Any glitch restarts that bit's count.
- Sensor classification on debounced bits:
  - izq = OR of bits above the centre; der = OR of bits below the centre; cen = centre bit.
- estado encoding: PARADO=0, RECTO=1, GIRO_IZQ=2, GIRO_DER=3, BUSCAR=4, PERDIDO=5.
- FSM transitions (registered, evaluated every clk):
  - habilitar=0 from any state -> PARADO.
  - PARADO with habilitar=1 -> decision.
  - Decision, in priority order:
    - no bit set -> BUSCAR;
    - izq&!der -> GIRO_IZQ;
    - der&!izq -> GIRO_DER;
    - otherwise -> RECTO.
  - RECTO, GIRO_IZQ and GIRO_DER re-run the decision every clk.
  - GIRO_IZQ and GIRO_DER record ultimo_lado (izq or der).
  - BUSCAR: any bit set -> decision. T_PERDIDO PWM-period wraps in BUSCAR -> PERDIDO. The timeout counter clears on leaving BUSCAR.
  - PERDIDO: any bit set -> decision; otherwise stay.
- Motor commands per state (direction fwd: INx=1,INy=0; rev: 0,1; off: 0,0):
  - PARADO and PERDIDO: duties 0, directions off.
  - RECTO: A fwd V_RECTO, B fwd V_RECTO.
  - GIRO_IZQ: A fwd V_GIRO, B fwd V_RECTO.
  - GIRO_DER: A fwd V_RECTO, B fwd V_GIRO.
  - BUSCAR: pivot toward ultimo_lado at V_BUSCA on both motors.
    - izq: A rev, B fwd.
    - der: A fwd, B rev.
- PWM:
  - Counter increments once every DIV_PWM clocks and wraps 2^PWM_BITS-1 -> 0.
  - ENA = (cnt < dutyA_shadow), registered; same for ENB.
  - Duty 0 gives a constant low; duty 2^PWM_BITS-1 gives high for all but one count.
- Shadow load: duty and direction shadows load on the clock where cnt wraps to 0. A state change mid-period does not alter the current period, so there are no partial pulses.
- Direction reversal on a motor: the first period after the change is forced to ENx=0 (dead period). The new direction then applies with ENx=0, followed by the normal duty from the next period.
- Latency: sensor edge -> debounced bit = 2 + DEB_CICLOS clks; -> estado = +1 clk; -> motor pins = next PWM wrap.
- habilitar falling mid-period: estado=PARADO next clk. ENA/ENB are forced 0 immediately (combinational gate on the registered ENx), without waiting for the wrap.
- Reset asserted mid-operation: all outputs low asynchronously.

Decomposition:
- Package seguidor_pkg: estado encoding constants; direction codes (fwd/rev/off); the sensor classification function.
- One sub-module, pwm_canal (counter compare + shadow duty/direction + dead period), instantiated twice with a shared counter input.
- Synchronizer/debounce, FSM and output logic inline.

Test Plan:
(All scenarios use default parameters.)
- Reset then habilitar=1, sensores=3'b010 -> estado=1 within 7 clks. After the next wrap, IN1=1 IN2=0 IN3=1 IN4=0, ENA high for 200 of 256 clks.
- sensores=3'b100 -> estado=2. ENA duty 80/256, ENB 200/256. Then sensores=3'b000 -> estado=4 with IN1=0 IN2=1 IN3=1 IN4=0. The first period after the reversal has ENA=0, then 120/256.
- Hold sensores=3'b000 -> estado=5 after 10 wraps, all motor outputs 0. Then sensores=3'b001 -> estado=3.
- 3-clk pulse on a sensor bit (< DEB_CICLOS) -> estado unchanged, no motor change.
- habilitar 1->0 mid-period -> ENA=ENB=0 same clk, estado=0 next clk. Reset pulse during RECTO -> all outputs 0 immediately.
- sensores=3'b101 -> estado=1 (both sides active -> RECTO).
